// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_scoreboard : multi-read register file with per-register busy     |
// |   scoreboard, flush and outstanding-reservation count.                   |
// |   Optional: REGFILE_BYPASS_EN enables write-to-read forwarding.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic              resv_ok,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam bit c_ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_pending_cnt;

  logic                w_wr_eff;
  logic [NUM_REGS-1:0] w_wr_mask;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [NUM_REGS-1:0] w_resv_mask;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [ADDR_W:0]     w_popcnt;

  // Writes to the hard-wired zero register are dropped before they touch any state.
  assign w_wr_eff  = wr_en & ~(c_ZERO_EN && (wr_addr == '0));
  assign w_wr_mask = w_wr_eff ? (NUM_REGS'(1) << wr_addr) : '0;

`ifdef REGFILE_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wr_mask;
`else
  assign w_busy_eff = r_busy;
`endif

  assign resv_ok = resv_en & ~w_busy_eff[resv_addr] & ~flush
                   & ~(c_ZERO_EN && (resv_addr == '0));
  assign w_resv_mask = resv_ok ? (NUM_REGS'(1) << resv_addr) : '0;

  // A same-cycle reservation is OR-ed in after the release, so it wins.
  assign w_busy_next = flush ? '0 : ((r_busy & ~w_wr_mask) | w_resv_mask);

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_popcnt = w_popcnt + (ADDR_W+1)'(w_busy_next[i]);
    end
  end

  // Returns {busy, data} as seen by a read port.
  function automatic logic [DATA_W:0] f_read(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] v;
    v = {r_busy[a], r_regs[a]};
`ifdef REGFILE_BYPASS_EN
    if (w_wr_eff && (wr_addr == a)) begin
      v = {1'b0, wr_data};
    end
`endif
    if (c_ZERO_EN && (a == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb {rd_busy1, rd_data1} = f_read(rd_addr1);
  always_comb {rd_busy2, rd_data2} = f_read(rd_addr2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy        <= '0;
      r_pending_cnt <= '0;
    end else begin
      if (w_wr_eff) begin
        r_regs[wr_addr] <= wr_data;
      end
      r_busy        <= w_busy_next;
      r_pending_cnt <= w_popcnt;
    end
  end

  assign pending_cnt = r_pending_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Scoreboard bench: two instances (ZERO_REG=0 and ZERO_REG=1) share one
// stimulus stream; an array-based model predicts outputs, a monitor compares.
module tb_regfile_scoreboard;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          b1;
    logic          b2;
    logic          ok;
    logic [AW:0]   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr1, rd_addr2, resv_addr, wr_addr;
  logic          resv_en, wr_en, flush;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] o_d1 [2];
  logic [DW-1:0] o_d2 [2];
  logic          o_b1 [2];
  logic          o_b2 [2];
  logic          o_ok [2];
  logic [AW:0]   o_cnt [2];

  logic [DW-1:0] m_mem  [2][NR];
  bit            m_busy [2][NR];
  exp_t          q0[$];
  exp_t          q1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_d1[0]), .rd_data2(o_d2[0]),
    .rd_busy1(o_b1[0]), .rd_busy2(o_b2[0]),
    .resv_en(resv_en), .resv_addr(resv_addr), .resv_ok(o_ok[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .pending_cnt(o_cnt[0])
  );

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_d1[1]), .rd_data2(o_d2[1]),
    .rd_busy1(o_b1[1]), .rd_busy2(o_b2[1]),
    .resv_en(resv_en), .resv_addr(resv_addr), .resv_ok(o_ok[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .pending_cnt(o_cnt[1])
  );

  function automatic logic rel_of(int z);
    return wr_en && !(z == 1 && wr_addr == 0);
  endfunction

  function automatic logic [DW-1:0] mdata(int z, logic [AW-1:0] a);
    if (z == 1 && a == 0) return '0;
    if (BYP && rel_of(z) && wr_addr == a) return wr_data;
    return m_mem[z][a];
  endfunction

  function automatic logic mbusy(int z, logic [AW-1:0] a);
    if (z == 1 && a == 0) return 1'b0;
    if (BYP && rel_of(z) && wr_addr == a) return 1'b0;
    return m_busy[z][a];
  endfunction

  function automatic exp_t model_out(int z);
    exp_t e;
    int   n = 0;
    e.d1 = mdata(z, rd_addr1);
    e.d2 = mdata(z, rd_addr2);
    e.b1 = mbusy(z, rd_addr1);
    e.b2 = mbusy(z, rd_addr2);
    e.ok = resv_en && !mbusy(z, resv_addr) && !flush && !(z == 1 && resv_addr == 0);
    for (int i = 0; i < NR; i++) n += int'(m_busy[z][i]);
    e.cnt = (AW+1)'(n);
    return e;
  endfunction

  task automatic model_clear();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NR; i++) begin
        m_mem[z][i]  = '0;
        m_busy[z][i] = 1'b0;
      end
  endtask

  task automatic model_edge(int z, logic ok);
    if (rel_of(z)) begin
      m_mem[z][wr_addr]  = wr_data;
      m_busy[z][wr_addr] = 1'b0;
    end
    if (ok) m_busy[z][resv_addr] = 1'b1;
    if (flush)
      for (int i = 0; i < NR; i++) m_busy[z][i] = 1'b0;
  endtask

  task automatic step(input logic r, input logic fl, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    exp_t e;
    @(negedge clk);
    rst = r; flush = fl; wr_en = we; wr_addr = wa; wr_data = wd;
    resv_en = re; resv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
    if (r) model_clear();
    for (int z = 0; z < 2; z++) begin
      e = model_out(z);
      if (z == 0) q0.push_back(e); else q1.push_back(e);
      if (!r) model_edge(z, e.ok);
    end
  endtask

  task automatic chk(input string nm, input int z, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, z, $time, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, after the driver has applied inputs at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int z = 0; z < 2; z++) begin
        if ((z == 0 && q0.size() > 0) || (z == 1 && q1.size() > 0)) begin
          e = (z == 0) ? q0.pop_front() : q1.pop_front();
          chk("rd_data1", z, int'(o_d1[z]), int'(e.d1));
          chk("rd_data2", z, int'(o_d2[z]), int'(e.d2));
          chk("rd_busy1", z, int'(o_b1[z]), int'(e.b1));
          chk("rd_busy2", z, int'(o_b2[z]), int'(e.b2));
          chk("resv_ok", z, int'(o_ok[z]), int'(e.ok));
          chk("pending_cnt", z, int'(o_cnt[z]), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    resv_en = 0; resv_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    model_clear();
    //   rst fl we wa  wd        re ra a1 a2
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(0, 0, 1, 3, 16'hBEEF, 0, 0, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 0, 0, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 1, 5, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 1, 5, 3, 5);
    step(0, 0, 1, 5, 16'h0042, 1, 5, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 0, 0, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 1, 3, 3, 5);
    step(0, 0, 0, 0, 16'h0000, 1, 5, 3, 5);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 3, 5);
    step(0, 0, 1, 3, 16'h1234, 0, 0, 3, 5);
    step(0, 0, 1, 2, 16'h1111, 1, 2, 2, 2);
    step(0, 0, 0, 0, 16'h0000, 1, 1, 2, 1);
    step(0, 0, 0, 0, 16'h0000, 1, 4, 2, 4);
    step(0, 1, 1, 7, 16'h7777, 1, 6, 7, 6);
    step(0, 0, 0, 0, 16'h0000, 0, 0, 7, 6);
    step(0, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    step(0, 0, 0, 0, 16'h0000, 0, 0, 0, 7);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0), AW'($urandom_range(0, NR-1)), DW'($urandom),
           ($urandom_range(0, 1) == 1), AW'($urandom_range(0, NR-1)),
           AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d expected=0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
